// File: rtl/avalon_counter_bank.sv
// Bank of NUM_CH prescaled up/down counters behind an Avalon-MM slave.
// Channel 0's value drives the LEDs; TC & IRQ_EN of all channels feed one level irq.
module avalon_counter_bank #(
   parameter int NUM_CH  = 2,
   parameter int WIDTH   = 10,
   parameter int PRESC_W = 16,
   parameter int ADDR_W  = $clog2(NUM_CH) + 2
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              irq,
   output logic [WIDTH-1:0]  counter_readdata
);

   localparam logic [1:0] R_CTRL = 2'd0, R_LIMIT = 2'd1, R_VALUE = 2'd2, R_STATUS = 2'd3;

   logic [NUM_CH-1:0]              en_q, en_d, down_q, down_d, sat_q, sat_d;
   logic [NUM_CH-1:0]              irqen_q, irqen_d, tc_q, tc_d;
   logic [NUM_CH-1:0][PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
   logic [NUM_CH-1:0][WIDTH-1:0]   limit_q, limit_d, value_q, value_d;
   logic [31:0]                    rdata_q, rdata_d;
   logic                           irq_q, irq_d;
   logic [WIDTH-1:0]               led_q;

   logic [ADDR_W-1:0] ch_sel;
   logic [1:0]        reg_sel;
   logic [NUM_CH-1:0] hit, tick, term;
   logic              unused_wdata;

   assign ch_sel       = avs_address >> 2;
   assign reg_sel      = avs_address[1:0];
   assign unused_wdata = ^avs_writedata;

   always_comb begin
      en_d    = en_q;
      down_d  = down_q;
      sat_d   = sat_q;
      irqen_d = irqen_q;
      tc_d    = tc_q;
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      limit_d = limit_q;
      value_d = value_q;
      hit     = '0;
      tick    = '0;
      term    = '0;
      rdata_d = rdata_q;
      for (int c = 0; c < NUM_CH; c++) begin
         // out-of-range channels never match, so their accesses fall through
         hit[c]  = (ch_sel == ADDR_W'(c));
         tick[c] = en_q[c] && (pcnt_q[c] == presc_q[c]);
         term[c] = down_q[c] ? (value_q[c] == '0) : (value_q[c] >= limit_q[c]);

         if (!en_q[c] || tick[c]) pcnt_d[c] = '0;
         else                     pcnt_d[c] = pcnt_q[c] + 1'b1;

         if (tick[c]) begin
            if (term[c]) begin
               tc_d[c] = 1'b1;
               if (!sat_q[c]) value_d[c] = down_q[c] ? limit_q[c] : '0;
            end else begin
               value_d[c] = down_q[c] ? value_q[c] - 1'b1 : value_q[c] + 1'b1;
            end
         end

         // software writes override the tick, except a TC clear loses to a TC set
         if (avs_write && hit[c]) begin
            case (reg_sel)
               R_CTRL: begin
                  en_d[c]    = avs_writedata[0];
                  down_d[c]  = avs_writedata[1];
                  sat_d[c]   = avs_writedata[2];
                  irqen_d[c] = avs_writedata[3];
                  presc_d[c] = avs_writedata[16 +: PRESC_W];
                  pcnt_d[c]  = '0;
               end
               R_LIMIT: limit_d[c] = avs_writedata[WIDTH-1:0];
               R_VALUE: begin
                  value_d[c] = avs_writedata[WIDTH-1:0];
                  pcnt_d[c]  = '0;
               end
               default: if (avs_writedata[0] && !(tick[c] && term[c])) tc_d[c] = 1'b0;
            endcase
         end
      end

      if (avs_read) begin
         rdata_d = '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (hit[c]) begin
               case (reg_sel)
                  R_CTRL: begin
                     rdata_d[3:0]            = {irqen_q[c], sat_q[c], down_q[c], en_q[c]};
                     rdata_d[16 +: PRESC_W]  = presc_q[c];
                  end
                  R_LIMIT:  rdata_d[WIDTH-1:0] = limit_q[c];
                  R_VALUE:  rdata_d[WIDTH-1:0] = value_q[c];
                  default:  rdata_d[0]         = tc_q[c];
               endcase
            end
         end
      end
   end

   assign irq_d = |(tc_q & irqen_q);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         en_q    <= '0;
         down_q  <= '0;
         sat_q   <= '0;
         irqen_q <= '0;
         tc_q    <= '0;
         presc_q <= '0;
         pcnt_q  <= '0;
         limit_q <= '0;
         value_q <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
         led_q   <= '0;
      end else begin
         en_q    <= en_d;
         down_q  <= down_d;
         sat_q   <= sat_d;
         irqen_q <= irqen_d;
         tc_q    <= tc_d;
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         limit_q <= limit_d;
         value_q <= value_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
         led_q   <= value_q[0];
      end
   end

   assign avs_readdata     = rdata_q;
   assign irq              = irq_q;
   assign counter_readdata = led_q;

endmodule

// File: tb/tb_avalon_counter_bank.sv
// Directed bench for avalon_counter_bank: expected values queued at stimulus time,
// popped and checked when the registered outputs are sampled on the falling edge.
module tb_avalon_counter_bank;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b1;
   logic [3:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        irq;
   logic [9:0]  counter_readdata;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   avalon_counter_bank #(.NUM_CH(2), .WIDTH(10), .PRESC_W(16), .ADDR_W(4)) dut (
      .clk_clk          (clk_clk),
      .reset_reset_n    (reset_reset_n),
      .avs_address      (avs_address),
      .avs_read         (avs_read),
      .avs_write        (avs_write),
      .avs_writedata    (avs_writedata),
      .avs_readdata     (avs_readdata),
      .irq              (irq),
      .counter_readdata (counter_readdata)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, obs, e);
   endtask

   // entered and left on a falling edge; the write lands on the rising edge between
   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk_clk);
      avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string tag);
      push(tag, e);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk_clk);
      avs_read    = 1'b0;
      pop_chk(avs_readdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #2 reset_reset_n = 1'b0;
      #1;
      chk("rst_readdata", avs_readdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_led", {22'b0, counter_readdata}, 32'h0);
      @(negedge clk_clk);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      for (int a = 0; a < 8; a++) rd(4'(a), 32'h0, $sformatf("rst_reg%0d", a));

      // ch0 up/wrap, PRESC=0, IRQ_EN on to observe when TC sets
      wr(4'd1, 32'd3);
      wr(4'd0, 32'h9);
      push("ch0_led1", 32'd0); push("ch0_led2", 32'd1); push("ch0_led3", 32'd2);
      push("ch0_led4", 32'd3); push("ch0_led5", 32'd0); push("ch0_led6", 32'd1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_clk);
         pop_chk({22'b0, counter_readdata});
         chk($sformatf("ch0_irq%0d", k), {31'b0, irq}, (k >= 5) ? 32'd1 : 32'd0);
      end
      wr(4'd0, 32'h0);
      wr(4'd3, 32'h1);
      rd(4'd2, 32'd3, "ch0_value_stopped");
      rd(4'd3, 32'd0, "ch0_tc_cleared");
      chk("ch0_irq_off", {31'b0, irq}, 32'h0);

      // ch1 down/sat, PRESC=2
      wr(4'd5, 32'd5);
      wr(4'd6, 32'd1);
      wr(4'd4, 32'h0002_0007);
      @(negedge clk_clk);
      @(negedge clk_clk);
      rd(4'd6, 32'd1, "ch1_before_tick");
      rd(4'd6, 32'd0, "ch1_first_tick");
      rd(4'd7, 32'd0, "ch1_tc_pre0");
      rd(4'd7, 32'd0, "ch1_tc_pre1");
      rd(4'd7, 32'd1, "ch1_tc_set");
      chk("ch1_irq_masked", {31'b0, irq}, 32'h0);
      repeat (5) @(negedge clk_clk);
      rd(4'd6, 32'd0, "ch1_sat_hold");
      chk("ch1_irq_masked2", {31'b0, irq}, 32'h0);
      wr(4'd4, 32'h0002_000F);
      chk("ch1_irq_lag", {31'b0, irq}, 32'h0);
      @(negedge clk_clk);
      chk("ch1_irq_on", {31'b0, irq}, 32'h1);
      @(negedge clk_clk);
      wr(4'd7, 32'h1);                       // collides with a terminal tick
      rd(4'd7, 32'd1, "ch1_tc_set_wins");
      chk("ch1_irq_still", {31'b0, irq}, 32'h1);
      wr(4'd7, 32'h1);                       // between ticks
      chk("ch1_irq_w1c_lag", {31'b0, irq}, 32'h1);
      rd(4'd7, 32'd0, "ch1_tc_w1c");
      chk("ch1_irq_w1c", {31'b0, irq}, 32'h0);
      wr(4'd4, 32'h0);

      // ch0 VALUE write colliding with a tick, PRESC=3
      wr(4'd1, 32'h3FF);
      wr(4'd0, 32'h0003_0001);
      repeat (3) @(negedge clk_clk);
      wr(4'd2, 32'h3FF);
      rd(4'd2, 32'h3FF, "ch0_write_wins");
      chk("ch0_led_3ff", {22'b0, counter_readdata}, 32'h3FF);
      push("ch0_hold6", 32'h3FF); push("ch0_hold7", 32'h3FF);
      push("ch0_hold8", 32'h3FF); push("ch0_wrap9", 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_clk);
         pop_chk({22'b0, counter_readdata});
      end
      wr(4'd0, 32'h0);

      // out-of-range channel and unused bits
      wr(4'd8, 32'hFFFF_FFFF);
      rd(4'd0, 32'h0, "oor_ch0_ctrl");
      rd(4'd1, 32'h3FF, "oor_ch0_limit");
      rd(4'd8, 32'h0, "oor_read8");
      rd(4'd11, 32'h0, "oor_read11");
      wr(4'd0, 32'h0000_0100);
      rd(4'd0, 32'h0, "ctrl_bit8");
      wr(4'd4, 32'hFFFF_FF0E);
      rd(4'd4, 32'hFFFF_000E, "ctrl_mask");
      wr(4'd5, 32'hFFFF_FFFF);
      rd(4'd5, 32'h3FF, "limit_trunc");

      // reset asserted mid-count
      wr(4'd2, 32'd5);
      wr(4'd0, 32'h9);
      chk("mid_led5", {22'b0, counter_readdata}, 32'd5);
      @(negedge clk_clk);
      chk("mid_led5b", {22'b0, counter_readdata}, 32'd5);
      chk("mid_irq", {31'b0, irq}, 32'h1);
      chk("mid_rdata", avs_readdata, 32'h3FF);
      #1 reset_reset_n = 1'b0;
      #1;
      chk("async_irq", {31'b0, irq}, 32'h0);
      chk("async_led", {22'b0, counter_readdata}, 32'h0);
      chk("async_rdata", avs_readdata, 32'h0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      rd(4'd2, 32'h0, "post_rst_value");
      rd(4'd3, 32'h0, "post_rst_tc");
      rd(4'd0, 32'h0, "post_rst_ctrl");
      rd(4'd5, 32'h0, "post_rst_ch1_limit");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/avalon_counter_bank.md
Name: avalon_counter_bank

Overview:
- Parametrised successor to the single 10-bit LED counter peripheral in the HPS–FPGA system.
- Holds NUM_CH independent up/down counters, each with its own prescaler, programmable limit and wrap or saturate mode.
- HPS software controls it over an Avalon-MM slave on the lightweight bridge.
- Exports channel 0's value to the LEDR pins and drives one level interrupt to the HPS.

Parameters:
- NUM_CH, 2, number of counter channels (1..8).
- WIDTH, 10, counter/limit width in bits (1..32).
- PRESC_W, 16, prescaler width in bits (1..16).
- ADDR_W, derived as clog2(NUM_CH)+2 (0 counts as 0); Avalon word address width.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- avs_address  in  ADDR_W  word address; channel = address[ADDR_W-1:2], register = address[1:0].
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed read latency 1.
- irq  out  1  level interrupt to the HPS.
- counter_readdata  out  WIDTH  channel 0 VALUE, registered, feeds the LEDs.

Behaviour:
- Reset: asynchronous on reset_reset_n low.
  - All registers, prescaler counters, avs_readdata, irq and counter_readdata go to 0.
  - Release takes effect on the next rising edge of clk_clk.
- Register map, per channel:
  - 0 CTRL: [0] EN, [1] DOWN, [2] SAT (1 = saturate, 0 = wrap), [3] IRQ_EN, [PRESC_W+15:16] PRESC.
  - 1 LIMIT: [WIDTH-1:0].
  - 2 VALUE: [WIDTH-1:0].
  - 3 STATUS: [0] TC, sticky terminal-count flag; writing 1 clears it.
  - Unused bits read 0. Accesses to channel index >= NUM_CH: reads return 0, writes are ignored.
- Read: avs_readdata is registered on the cycle after avs_read. No waitrequest. Reads have no side effects.
- Prescaler, per channel:
  - pcnt increments each cycle while EN=1.
  - When pcnt==PRESC, a tick is issued and pcnt returns to 0, so the tick period is PRESC+1 cycles. PRESC=0 gives a tick every cycle.
  - EN=0 holds pcnt at 0.
  - Any CTRL write clears pcnt.
- Count on tick:
  - Up mode: if VALUE>=LIMIT, then VALUE becomes 0 (wrap) or holds (SAT), and TC is set. Otherwise VALUE+1.
  - Down mode: if VALUE==0, then VALUE becomes LIMIT (wrap) or holds (SAT), and TC is set. Otherwise VALUE-1.
  - In SAT mode TC is set again on every tick at the terminal value (it is already set, so it stays set).
- Simultaneous events, same cycle:
  - Software write to VALUE and a tick: the write wins and pcnt is cleared.
  - TC set and a W1C of TC: set wins, so TC stays 1.
  - LIMIT is written below the current VALUE in up mode: the next tick is terminal.
- Interrupt: irq is registered and equals OR over channels of (TC & IRQ_EN), so it follows TC/IRQ_EN by 1 cycle.
- counter_readdata: registered copy of channel 0 VALUE, 1 cycle behind.
- Arithmetic: all counter and limit arithmetic is modulo 2^WIDTH. writedata above WIDTH or PRESC_W bits is truncated.

Test Plan:
- Reset → all outputs 0 and all registers read 0. Assert reset mid-count (ch0 VALUE=5) → VALUE, irq and counter_readdata are 0 asynchronously, before the next edge.
- ch0: LIMIT=3, CTRL=0x1 (up, wrap, PRESC=0) → VALUE sequence 1,2,3,0,1 on consecutive cycles. TC sets on the 3→0 tick. counter_readdata lags VALUE by 1 cycle.
- ch1: LIMIT=5, VALUE=1, CTRL=0x0002_0007 (down, sat, PRESC=2) → ticks every 3 cycles: VALUE 0, then holds 0. TC=1. irq stays 0 until IRQ_EN is set, then irq=1 one cycle later. W1C STATUS → irq=0 one cycle later.
- Write VALUE=0x3FF on the same cycle as a ch0 tick → VALUE reads 0x3FF. The next tick occurs PRESC+1 cycles later.
- W1C of TC on the same cycle a terminal tick occurs → TC reads 1.
- NUM_CH=2: write to address 8 (channel 2) → no register changes. Reading address 8 → 0. Reading an unused CTRL bit (bit 8) → 0.
